// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detected sources, mask/pending registers, and a
// hold/ack handshake with the decoder before the core enters the handler.
module int_ctrl #(
    parameter int NSRC   = 4,
    parameter int TO_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    input  logic            we,
    input  logic [4:0]      addr,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    input  logic            hold_ack,
    output logic            hold,
    output logic            exl,
    output logic            iv,
    output logic [2:0]      irq_id
);
    localparam int CW = $clog2(TO_CYC + 1);
    localparam logic [4:0] A_MASK = 5'b11000;
    localparam logic [4:0] A_PEND = 5'b11001;
    localparam logic [4:0] A_CAUSE = 5'b11010;
    localparam logic [4:0] A_ACK = 5'b11011;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2, DONE = 2'd3} state_t;

    state_t          state;
    logic [NSRC-1:0] prev, pending, mask, active, set_v, clr_v, ack_clr;
    logic            armed, to_err;
    logic [CW-1:0]   cnt;
    logic [7:0]      act8;
    logic [2:0]      first_id;
    logic            wr_mask, wr_pend, wr_ack;

    assign wr_mask = we && (addr == A_MASK);
    assign wr_pend = we && (addr == A_PEND);
    assign wr_ack  = we && (addr == A_ACK);
    assign active  = pending & mask;
    assign act8    = 8'(active);
    assign ack_clr = NSRC'(8'd1 << irq_id);

    // armed holds off edge detection until prev has captured irq_in once after reset
    assign set_v = irq_in & ~prev & {NSRC{armed}};
    assign clr_v = (wr_pend ? wd[NSRC-1:0] : '0) |
                   ((wr_ack && state == SVC) ? ack_clr : '0);

    always_comb begin
        first_id = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (active[i]) first_id = 3'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            armed   <= 1'b0;
            pending <= '0;
            mask    <= '0;
        end else begin
            prev    <= irq_in;
            armed   <= 1'b1;
            pending <= (pending & ~clr_v) | set_v;
            if (wr_mask) mask <= wd[NSRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            irq_id <= 3'd0;
            cnt    <= '0;
            to_err <= 1'b0;
            hold   <= 1'b0;
            exl    <= 1'b0;
            iv     <= 1'b0;
        end else begin
            if (wr_pend && wd[31]) to_err <= 1'b0;
            case (state)
                IDLE: begin
                    hold <= 1'b0;
                    exl  <= 1'b0;
                    iv   <= 1'b0;
                    if (|active) begin
                        irq_id <= first_id;
                        cnt    <= '0;
                        state  <= REQ;
                        hold   <= 1'b1;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (hold_ack) begin
                        state <= SVC;
                        hold  <= 1'b0;
                        exl   <= 1'b1;
                        iv    <= (irq_id == 3'd0);
                    end else if (!act8[irq_id]) begin
                        state <= IDLE;
                        hold  <= 1'b0;
                    end else if (cnt == CW'(TO_CYC - 1)) begin
                        // a timeout on the same edge as a clearing write keeps to_err set
                        state  <= IDLE;
                        hold   <= 1'b0;
                        to_err <= 1'b1;
                    end
                end
                SVC: begin
                    if (wr_ack) begin
                        state <= DONE;
                        exl   <= 1'b0;
                        iv    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd = 32'd0;
        case (addr)
            A_MASK:  rd[NSRC-1:0] = mask;
            A_PEND:  rd[NSRC-1:0] = pending;
            A_CAUSE: rd = {(state != IDLE), 25'd0, to_err, irq_id, state};
            default: rd = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: scenario tasks with inline checks, plus a scoreboard of
// expected {irq_id, iv} popped whenever the core enters a handler.
`timescale 1ns/100ps
module tb_int_ctrl;
    localparam logic [4:0] A_MASK = 5'b11000;
    localparam logic [4:0] A_PEND = 5'b11001;
    localparam logic [4:0] A_CAUSE = 5'b11010;
    localparam logic [4:0] A_ACK = 5'b11011;

    logic        clk, rst, we, hold_ack, hold, exl, iv;
    logic [3:0]  irq_in;
    logic [4:0]  addr;
    logic [31:0] wd, rd, d;
    logic [2:0]  irq_id;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic exl_q = 1'b0;

    int_ctrl #(.NSRC(4), .TO_CYC(16)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .addr(addr), .wd(wd),
        .rd(rd), .hold_ack(hold_ack), .hold(hold), .exl(exl), .iv(iv), .irq_id(irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: every handler entry must match the oldest expected service
    always @(posedge clk) begin
        #1;
        if (rst) exl_q = 1'b0;
        else begin
            if (exl && !exl_q) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL svc_entry unexpected service id=%0d iv=%0b", irq_id, iv);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if ({irq_id, iv} !== e) begin
                        errors++;
                        $display("FAIL svc_entry got id=%0d iv=%0b want id=%0d iv=%0b",
                                 irq_id, iv, e[3:1], e[0]);
                    end
                end
            end
            exl_q = exl;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rdreg(input logic [4:0] a, output logic [31:0] v);
        addr = a; #1; v = rd;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        addr = a; wd = v; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic wait_exl(input string nm);
        int n = 0;
        while (!exl && n < 20) begin tick(); n++; end
        checks++;
        if (!exl) begin errors++; $display("FAIL %s exl never rose", nm); end
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; addr = '0; wd = '0; hold_ack = 1'b0; irq_in = 4'b0001;
        repeat (3) tick();
        checks++;
        if ({hold, exl, iv} !== 3'b000) begin errors++; $display("FAIL reset_outs got %b want 000", {hold, exl, iv}); end
        for (int i = 0; i < 4; i++) begin
            rdreg(A_MASK + 5'(i), d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", i, d); end
        end
        // irq_in already high at release must not register as an edge
        rst = 1'b0;
        wr(A_MASK, 32'hF);
        repeat (2) tick();
        rdreg(A_PEND, d);
        checks++;
        if (d !== 32'd0 || hold !== 1'b0) begin errors++; $display("FAIL release_edge pend=%h hold=%b want 0 0", d, hold); end
        irq_in = 4'b0000;
        wr(A_MASK, 32'h0);
        tick();
    endtask

    task automatic test_timer();
        wr(A_MASK, 32'h3);
        irq_in = 4'b0001; tick(); irq_in = 4'b0000;
        rdreg(A_PEND, d);
        checks++;
        if (d !== 32'h1 || hold !== 1'b0) begin errors++; $display("FAIL timer_pend pend=%h hold=%b want 1 0", d, hold); end
        tick();
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL timer_hold got %b want 1", hold); end
        exp_q.push_back({3'd0, 1'b1});
        hold_ack = 1'b1; tick(); hold_ack = 1'b0;
        checks++;
        if ({hold, exl, iv} !== 3'b011) begin errors++; $display("FAIL timer_svc got %b want 011", {hold, exl, iv}); end
        tick(); tick();
        wr(A_ACK, 32'hDEAD);
        rdreg(A_PEND, d);
        checks++;
        if (d !== 32'd0 || exl !== 1'b0) begin errors++; $display("FAIL timer_ack pend=%h exl=%b want 0 0", d, exl); end
        rdreg(A_CAUSE, d);
        checks++;
        if (d !== 32'h8000_0003) begin errors++; $display("FAIL timer_done cause=%h want 80000003", d); end
        tick();
        rdreg(A_CAUSE, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL timer_idle cause=%h want 0", d); end
    endtask

    task automatic test_priority();
        wr(A_MASK, 32'hF);
        irq_in = 4'b0110; tick(); irq_in = 4'b0000;
        tick();
        checks++;
        if (hold !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL prio_req hold=%b id=%0d want 1 1", hold, irq_id); end
        exp_q.push_back({3'd1, 1'b0});
        exp_q.push_back({3'd2, 1'b0});
        hold_ack = 1'b1;
        wait_exl("prio_first");
        wr(A_ACK, 32'h0);
        rdreg(A_CAUSE, d);
        checks++;
        if (exl !== 1'b0 || d[1:0] !== 2'd3) begin errors++; $display("FAIL prio_gap exl=%b state=%0d want 0 3", exl, d[1:0]); end
        wait_exl("prio_second");
        checks++;
        if (irq_id !== 3'd2) begin errors++; $display("FAIL prio_second id=%0d want 2", irq_id); end
        wr(A_ACK, 32'h0);
        tick();
        hold_ack = 1'b0;
        rdreg(A_PEND, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL prio_clear pend=%h want 0", d); end
    endtask

    task automatic test_timeout();
        int n;
        wr(A_MASK, 32'h1);
        irq_in = 4'b0001; tick(); irq_in = 4'b0000;
        tick();
        n = hold ? 1 : 0;
        while (hold && n < 40) begin tick(); if (hold) n++; end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL to_len hold cycles=%0d want 16", n); end
        rdreg(A_CAUSE, d);
        checks++;
        if (d[5] !== 1'b1 || d[1:0] !== 2'd0) begin errors++; $display("FAIL to_err cause=%h want bit5=1 state=0", d); end
        rdreg(A_PEND, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL to_pend pend=%h want 1", d); end
        tick();
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL to_retry hold=%b want 1", hold); end
        wr(A_MASK, 32'h0);
        wr(A_PEND, 32'h8000_0001);
        tick();
        rdreg(A_CAUSE, d);
        checks++;
        if (d[5] !== 1'b0 || d[1:0] !== 2'd0) begin errors++; $display("FAIL to_clear cause=%h want bit5=0 idle", d); end
    endtask

    task automatic test_abort();
        wr(A_MASK, 32'h1);
        irq_in = 4'b0001; tick(); irq_in = 4'b0000;
        tick();
        wr(A_MASK, 32'h0);
        tick();
        rdreg(A_CAUSE, d);
        checks++;
        if (hold !== 1'b0 || d[1:0] !== 2'd0) begin errors++; $display("FAIL abort hold=%b state=%0d want 0 0", hold, d[1:0]); end
        rdreg(A_PEND, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL abort_pend pend=%h want 1", d); end
        wr(A_MASK, 32'h1);
        tick();
        checks++;
        if (hold !== 1'b1) begin errors++; $display("FAIL abort_restart hold=%b want 1", hold); end
        exp_q.push_back({3'd0, 1'b1});
        hold_ack = 1'b1;
        wait_exl("abort_svc");
    endtask

    task automatic test_back_to_back();
        // in SVC for bit 0: a fresh edge lands on the same edge as the ACK write
        irq_in = 4'b0001; addr = A_ACK; we = 1'b1;
        tick();
        we = 1'b0; irq_in = 4'b0000;
        rdreg(A_PEND, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL set_wins pend=%h want 1", d); end
        exp_q.push_back({3'd0, 1'b1});
        wait_exl("set_wins_resvc");
    endtask

    task automatic test_async_reset();
        checks++;
        if (exl !== 1'b1) begin errors++; $display("FAIL async_pre exl=%b want 1", exl); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({hold, exl, iv} !== 3'b000) begin errors++; $display("FAIL async_drop got %b want 000", {hold, exl, iv}); end
        hold_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            rdreg(A_MASK + 5'(i), d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL async_reg%0d got %h want 0", i, d); end
        end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_priority();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_async_reset();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain left=%0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
